// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the memory-port arbiter. word_t and mem_addr_t are the
//   same types the core already uses on its own memory interface. The other
//   types are the arbiter FSM state, the read-return owner tag and the
//   8-bit width of the wait/burst counters.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  mem_addr_t;
  typedef logic [7:0]  cnt_t;

  typedef enum logic {ARB, D_BURST} arb_state_t;
  typedef enum logic {OWN_C, OWN_D} owner_t;

  localparam cnt_t CntSat = 8'hFF;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles every bus signal around the arbiter.
//   c_* : core requester (req/wren/addr/size/wdata in, gnt/rvalid/rdata out)
//   d_* : DMA/debug requester, same signals plus d_lock (hold ownership)
//   mem_*/memwrite_data/memread_data : the single synchronous memory port
//   Modport slave is the arbiter's view. Modport master is the combined view
//   of both requesters and the memory.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic      c_req;
  logic      c_wren;
  word_t     c_addr;
  mem_addr_t c_size;
  word_t     c_wdata;
  logic      c_gnt;
  logic      c_rvalid;
  word_t     c_rdata;

  logic      d_req;
  logic      d_wren;
  word_t     d_addr;
  mem_addr_t d_size;
  word_t     d_wdata;
  logic      d_lock;
  logic      d_gnt;
  logic      d_rvalid;
  word_t     d_rdata;

  word_t     mem_addr;
  logic      mem_rden;
  logic      mem_wren;
  mem_addr_t mem_size;
  word_t     memwrite_data;
  word_t     memread_data;

  modport slave (
    input  c_req, c_wren, c_addr, c_size, c_wdata,
    input  d_req, d_wren, d_addr, d_size, d_wdata, d_lock,
    input  memread_data,
    output c_gnt, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_rden, mem_wren, mem_size, memwrite_data
  );

  modport master (
    output c_req, c_wren, c_addr, c_size, c_wdata,
    output d_req, d_wren, d_addr, d_size, d_wdata, d_lock,
    output memread_data,
    input  c_gnt, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_rden, mem_wren, mem_size, memwrite_data
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one synchronous memory port between the core (C) and a DMA/debug
//   loader (D). C has fixed priority. D wins a contested cycle once it has
//   been denied MAX_WAIT cycles in a row. D may hold the port for up to
//   MAX_BURST consecutive grants by asserting d_lock.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     bus  - mem_arbiter_if.slave: requester handshakes and the memory port
//   Grants and mem_* outputs are combinational, so an uncontested request
//   sees no added latency. Read data is returned one cycle after the grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);

  localparam cnt_t MaxWaitC  = cnt_t'(MAX_WAIT);
  localparam cnt_t MaxBurstC = cnt_t'(MAX_BURST);

  arb_state_t state_q, state_d;
  cnt_t       waitCnt_q, waitCnt_d;
  cnt_t       burstCnt_q, burstCnt_d;
  logic       rdPend_q, rdPend_d;
  owner_t     rdOwner_q, rdOwner_d;

  logic       dWin;
  logic       cGnt;
  logic       dGnt;
  cnt_t       burstNext;

  // Decide who owns the port this cycle. Inside a burst D keeps the port
  // whenever it still requests. Otherwise C wins unless D has waited long
  // enough. Reset blocks every grant so nothing reaches memory while the
  // state is being cleared.
  always_comb begin
    dWin = 1'b0;
    if (state_q == D_BURST) begin
      dWin = bus.d_req;
    end else begin
      dWin = bus.d_req & (!bus.c_req | (waitCnt_q >= MaxWaitC));
    end
    dGnt = dWin & !rst;
    cGnt = bus.c_req & !dWin & !rst;
  end

  assign bus.c_gnt = cGnt;
  assign bus.d_gnt = dGnt;

  // Drive the memory port from whichever requester owns it. The port is
  // held at all zeros when nobody owns it.
  always_comb begin
    bus.mem_addr      = '0;
    bus.mem_rden      = 1'b0;
    bus.mem_wren      = 1'b0;
    bus.mem_size      = '0;
    bus.memwrite_data = '0;
    if (cGnt) begin
      bus.mem_addr      = bus.c_addr;
      bus.mem_rden      = !bus.c_wren;
      bus.mem_wren      = bus.c_wren;
      bus.mem_size      = bus.c_size;
      bus.memwrite_data = bus.c_wdata;
    end else if (dGnt) begin
      bus.mem_addr      = bus.d_addr;
      bus.mem_rden      = !bus.d_wren;
      bus.mem_wren      = bus.d_wren;
      bus.mem_size      = bus.d_size;
      bus.memwrite_data = bus.d_wdata;
    end
  end

  // Next-state logic for the starvation counter, the burst FSM and the
  // read-return tracker. A granted D access always clears the wait count.
  // So after any burst exit the next arbitration cycle starts from zero
  // and C wins if it is waiting.
  always_comb begin
    state_d    = state_q;
    burstCnt_d = burstCnt_q;
    burstNext  = burstCnt_q + 8'd1;

    if (bus.d_req && !dGnt) begin
      waitCnt_d = (waitCnt_q == CntSat) ? waitCnt_q : waitCnt_q + 8'd1;
    end else begin
      waitCnt_d = '0;
    end

    case (state_q)
      ARB: begin
        if (dGnt && bus.d_lock && (8'd1 < MaxBurstC)) begin
          state_d    = D_BURST;
          burstCnt_d = 8'd1;
        end else begin
          burstCnt_d = '0;
        end
      end
      D_BURST: begin
        if (!bus.d_req || !bus.d_lock || (burstNext >= MaxBurstC)) begin
          state_d    = ARB;
          burstCnt_d = '0;
        end else begin
          burstCnt_d = burstNext;
        end
      end
      default: begin
        state_d    = ARB;
        burstCnt_d = '0;
      end
    endcase

    rdPend_d  = (cGnt & !bus.c_wren) | (dGnt & !bus.d_wren);
    rdOwner_d = dGnt ? OWN_D : OWN_C;
  end

  // State registers. Reset returns to plain arbitration with no read
  // outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      waitCnt_q  <= '0;
      burstCnt_q <= '0;
      rdPend_q   <= 1'b0;
      rdOwner_q  <= OWN_C;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      burstCnt_q <= burstCnt_d;
      rdPend_q   <= rdPend_d;
      rdOwner_q  <= rdOwner_d;
    end
  end

  // Read data goes to both requesters unchanged. Only the owner of the
  // outstanding read sees rvalid. A reset in the return cycle squashes it.
  assign bus.c_rvalid = rdPend_q & (rdOwner_q == OWN_C) & !rst;
  assign bus.d_rvalid = rdPend_q & (rdOwner_q == OWN_D) & !rst;
  assign bus.c_rdata  = bus.memread_data;
  assign bus.d_rdata  = bus.memread_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed test of mem_arbiter with MAX_WAIT=8 and MAX_BURST=4. A small
//   memory model answers every mem_rden one cycle later. Expected read
//   returns are queued when a read is expected to be granted, then popped
//   and compared in the following cycle.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic  isD;
    word_t data;
  } rdItem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int assertCount = 0;
  int failCount   = 0;

  rdItem_t rdQ[$];

  logic  cWrenV;
  word_t cAddrV;
  word_t cWdataV;
  logic  dWrenV;
  word_t dAddrV;
  word_t dWdataV;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_WAIT (8),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory contents as seen by the bench. Address 0x100 holds 0xDEADBEEF.
  // Every other word is derived from its address.
  function automatic word_t memFn(input word_t a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  // Synchronous memory: read data is valid the cycle after mem_rden.
  always @(posedge clk) begin
    bus.memread_data <= bus.mem_rden ? memFn(bus.mem_addr) : '0;
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input word_t obs, input word_t exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare this cycle's read-return outputs against the oldest queued read.
  task automatic checkReturn(input string tag);
    rdItem_t it;
    if (rdQ.size() > 0) begin
      it = rdQ.pop_front();
      checkOutput({tag, " c_rvalid"}, 32'(bus.c_rvalid), 32'(!it.isD));
      checkOutput({tag, " d_rvalid"}, 32'(bus.d_rvalid), 32'(it.isD));
      if (it.isD) checkOutput({tag, " d_rdata"}, bus.d_rdata, it.data);
      else        checkOutput({tag, " c_rdata"}, bus.c_rdata, it.data);
    end else begin
      checkOutput({tag, " c_rvalid idle"}, 32'(bus.c_rvalid), 32'd0);
      checkOutput({tag, " d_rvalid idle"}, 32'(bus.d_rvalid), 32'd0);
    end
  endtask

  // Advance one clock, drive a new cycle of inputs, and check the read
  // return that belongs to the previous cycle.
  task automatic applyStimulus(
    input string tag,
    input logic r,
    input logic cReq, input logic cWren, input word_t cAddr, input word_t cWdata,
    input logic dReq, input logic dWren, input logic dLock,
    input word_t dAddr, input word_t dWdata
  );
    @(posedge clk);
    #1;
    rst           = r;
    bus.c_req     = cReq;
    bus.c_wren    = cWren;
    bus.c_addr    = cAddr;
    bus.c_size    = 2'd2;
    bus.c_wdata   = cWdata;
    bus.d_req     = dReq;
    bus.d_wren    = dWren;
    bus.d_lock    = dLock;
    bus.d_addr    = dAddr;
    bus.d_size    = 2'd1;
    bus.d_wdata   = dWdata;
    cWrenV        = cWren;
    cAddrV        = cAddr;
    cWdataV       = cWdata;
    dWrenV        = dWren;
    dAddrV        = dAddr;
    dWdataV       = dWdata;
    #1;
    checkReturn(tag);
  endtask

  // Check the grants and the memory-side mux for the expected owner. If a
  // read is expected to be granted, queue its return.
  task automatic checkGrant(input string tag, input logic expC, input logic expD);
    word_t     eAddr;
    word_t     eWdata;
    logic      eRden;
    logic      eWren;
    mem_addr_t eSize;
    eAddr  = '0;
    eWdata = '0;
    eRden  = 1'b0;
    eWren  = 1'b0;
    eSize  = '0;
    if (expC) begin
      eAddr = cAddrV; eWdata = cWdataV; eRden = !cWrenV; eWren = cWrenV; eSize = 2'd2;
    end else if (expD) begin
      eAddr = dAddrV; eWdata = dWdataV; eRden = !dWrenV; eWren = dWrenV; eSize = 2'd1;
    end
    checkOutput({tag, " c_gnt"}, 32'(bus.c_gnt), 32'(expC));
    checkOutput({tag, " d_gnt"}, 32'(bus.d_gnt), 32'(expD));
    checkOutput({tag, " mem_addr"}, bus.mem_addr, eAddr);
    checkOutput({tag, " mem_rden"}, 32'(bus.mem_rden), 32'(eRden));
    checkOutput({tag, " mem_wren"}, 32'(bus.mem_wren), 32'(eWren));
    checkOutput({tag, " mem_size"}, 32'(bus.mem_size), 32'(eSize));
    checkOutput({tag, " memwrite_data"}, bus.memwrite_data, eWdata);
    if (expC && !cWrenV) rdQ.push_back('{1'b0, memFn(cAddrV)});
    if (expD && !dWrenV) rdQ.push_back('{1'b1, memFn(dAddrV)});
  endtask

  initial begin
    bus.c_req  = 1'b1;
    bus.d_req  = 1'b1;
    bus.c_wren = 1'b0;
    bus.d_wren = 1'b0;
    bus.d_lock = 1'b0;
    bus.c_addr = '0;
    bus.d_addr = '0;
    bus.c_size = '0;
    bus.d_size = '0;
    bus.c_wdata = '0;
    bus.d_wdata = '0;

    // Reset held three cycles with both requesting: nothing is granted.
    for (int i = 0; i < 3; i++) begin
      applyStimulus("reset", 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
      checkGrant("reset", 1'b0, 1'b0);
    end

    // First cycle out of reset with both requesting: C wins.
    applyStimulus("post_reset", 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    checkGrant("post_reset", 1'b1, 1'b0);

    // C-only read of 0x100, then idle while the data returns.
    applyStimulus("c_only", 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("c_only", 1'b1, 1'b0);
    applyStimulus("idle1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("idle1", 1'b0, 1'b0);
    applyStimulus("idle2", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("idle2", 1'b0, 1'b0);

    // Continuous contention: eight C grants, then one D grant, repeated.
    for (int i = 0; i < 18; i++) begin
      applyStimulus("contend", 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0);
      checkGrant("contend", (i % 9) != 8, (i % 9) == 8);
    end
    applyStimulus("idle3", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("idle3", 1'b0, 1'b0);

    // Locked D writes against constant C reads. D starves for eight cycles,
    // then holds the port for exactly four grants, and C follows.
    for (int i = 0; i < 14; i++) begin
      applyStimulus("burst", 1'b0, 1'b1, 1'b0, 32'h340, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h480, 32'h1000 + 32'(i));
      checkGrant("burst", !(i >= 8 && i <= 11), (i >= 8 && i <= 11));
    end
    applyStimulus("idle4", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("idle4", 1'b0, 1'b0);

    // A burst keeps D ahead of C, and dropping d_lock ends the burst.
    applyStimulus("lock_enter", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h480, 32'h0);
    checkGrant("lock_enter", 1'b0, 1'b1);
    applyStimulus("lock_drop", 1'b0, 1'b1, 1'b0, 32'h340, 32'h0, 1'b1, 1'b0, 1'b0, 32'h484, 32'h0);
    checkGrant("lock_drop", 1'b0, 1'b1);
    applyStimulus("after_drop", 1'b0, 1'b1, 1'b0, 32'h340, 32'h0, 1'b1, 1'b0, 1'b1, 32'h488, 32'h0);
    checkGrant("after_drop", 1'b1, 1'b0);
    applyStimulus("idle5", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("idle5", 1'b0, 1'b0);

    // C read then D write with no idle cycle between them.
    applyStimulus("alt_c_read", 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("alt_c_read", 1'b1, 1'b0);
    applyStimulus("alt_d_write", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h55);
    checkGrant("alt_d_write", 1'b0, 1'b1);
    applyStimulus("idle6", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("idle6", 1'b0, 1'b0);

    // Locked D read enters a burst. Reset in the return cycle squashes
    // d_rvalid and returns to arbitration, so C then beats a locked D.
    applyStimulus("rd_before_rst", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h700, 32'h0);
    checkGrant("rd_before_rst", 1'b0, 1'b1);
    rdQ.delete();
    applyStimulus("rst_pulse", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("rst_pulse", 1'b0, 1'b0);
    applyStimulus("after_rst", 1'b0, 1'b1, 1'b0, 32'h340, 32'h0, 1'b1, 1'b0, 1'b1, 32'h704, 32'h0);
    checkGrant("after_rst", 1'b1, 1'b0);
    applyStimulus("final", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkGrant("final", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
